// File: rtl/order_table.sv
// Live-order table: accepts ADD/DELETE/EXECUTE messages, scans one slot per cycle, commits and emits a response.
// Optional per-type statistics counters are enabled by defining ORDER_TABLE_STATS_EN.
module order_table #(
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  ADD_CODE  = 8'h41,
  parameter logic [7:0]  DEL_CODE  = 8'h44,
  parameter logic [7:0]  EXEC_CODE = 8'h45
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         msg_valid,
  input  logic [7:0]                   msg_type,
  input  logic [7:0]                   stock_id,
  input  logic [31:0]                  order_id,
  input  logic [31:0]                  price,
  input  logic [31:0]                  quantity,
  output logic                         msg_ready,
  output logic                         msg_drop,
  output logic                         resp_valid,
  output logic [7:0]                   resp_type,
  output logic [2:0]                   resp_status,
  output logic [31:0]                  resp_order_id,
  output logic [7:0]                   resp_stock_id,
  output logic [31:0]                  resp_price,
  output logic [31:0]                  resp_qty_left,
`ifdef ORDER_TABLE_STATS_EN
  output logic [15:0]                  add_cnt,
  output logic [15:0]                  del_cnt,
  output logic [15:0]                  exec_cnt,
  output logic [15:0]                  err_cnt,
  output logic [15:0]                  drop_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int IW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_NOT_FOUND = 3'd1;
  localparam logic [2:0] ST_FULL      = 3'd2;
  localparam logic [2:0] ST_DUP       = 3'd3;
  localparam logic [2:0] ST_BAD_TYPE  = 3'd4;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          free_found_q, free_found_d;
  logic [IW-1:0] free_idx_q, free_idx_d;
  logic [OW-1:0] occ_q, occ_d;

  logic [7:0]  m_type_q, m_type_d;
  logic [7:0]  m_sid_q, m_sid_d;
  logic [31:0] m_oid_q, m_oid_d;
  logic [31:0] m_px_q, m_px_d;
  logic [31:0] m_qty_q, m_qty_d;

  logic        valid_q [DEPTH];
  logic        valid_d [DEPTH];
  logic [31:0] oid_q   [DEPTH];
  logic [31:0] oid_d   [DEPTH];
  logic [7:0]  sid_q   [DEPTH];
  logic [7:0]  sid_d   [DEPTH];
  logic [31:0] px_q    [DEPTH];
  logic [31:0] px_d    [DEPTH];
  logic [31:0] qty_q   [DEPTH];
  logic [31:0] qty_d   [DEPTH];

  logic [7:0]  resp_type_q, resp_type_d;
  logic [2:0]  resp_status_q, resp_status_d;
  logic [31:0] resp_oid_q, resp_oid_d;
  logic [7:0]  resp_sid_q, resp_sid_d;
  logic [31:0] resp_px_q, resp_px_d;
  logic [31:0] resp_qty_q, resp_qty_d;

  logic          hit, last, done, is_add, cur_free, slot_found;
  logic [IW-1:0] slot_idx;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    occ_d         = occ_q;
    m_type_d      = m_type_q;
    m_sid_d       = m_sid_q;
    m_oid_d       = m_oid_q;
    m_px_d        = m_px_q;
    m_qty_d       = m_qty_q;
    valid_d       = valid_q;
    oid_d         = oid_q;
    sid_d         = sid_q;
    px_d          = px_q;
    qty_d         = qty_q;
    resp_type_d   = resp_type_q;
    resp_status_d = resp_status_q;
    resp_oid_d    = resp_oid_q;
    resp_sid_d    = resp_sid_q;
    resp_px_d     = resp_px_q;
    resp_qty_d    = resp_qty_q;
    hit           = valid_q[idx_q] && (oid_q[idx_q] == m_oid_q);
    last          = (idx_q == IW'(DEPTH-1));
    is_add        = (m_type_q == ADD_CODE);
    cur_free      = !valid_q[idx_q];
    slot_found    = free_found_q || cur_free;
    slot_idx      = free_found_q ? free_idx_q : idx_q;
    done          = 1'b0;

    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          m_type_d = msg_type;
          m_sid_d  = stock_id;
          m_oid_d  = order_id;
          m_px_d   = price;
          m_qty_d  = quantity;
          if (msg_type == ADD_CODE || msg_type == DEL_CODE || msg_type == EXEC_CODE) begin
            state_d      = SCAN;
            idx_d        = '0;
            free_found_d = 1'b0;
            free_idx_d   = '0;
          end else begin
            state_d       = COMMIT;
            resp_type_d   = msg_type;
            resp_status_d = ST_BAD_TYPE;
            resp_oid_d    = order_id;
            resp_sid_d    = '0;
            resp_px_d     = '0;
            resp_qty_d    = '0;
          end
        end
      end

      // The table and response are committed on the edge that leaves SCAN,
      // so they are already stable for the whole COMMIT cycle.
      SCAN: begin
        resp_type_d = m_type_q;
        resp_oid_d  = m_oid_q;
        if (is_add) begin
          free_found_d = slot_found;
          free_idx_d   = slot_idx;
          resp_sid_d   = m_sid_q;
          resp_px_d    = m_px_q;
          resp_qty_d   = '0;
          if (hit) begin
            done          = 1'b1;
            resp_status_d = ST_DUP;
          end else if (last) begin
            done = 1'b1;
            if (!slot_found) begin
              resp_status_d = ST_FULL;
            end else begin
              resp_status_d   = ST_OK;
              resp_qty_d      = m_qty_q;
              valid_d[slot_idx] = 1'b1;
              oid_d[slot_idx]   = m_oid_q;
              sid_d[slot_idx]   = m_sid_q;
              px_d[slot_idx]    = m_px_q;
              qty_d[slot_idx]   = m_qty_q;
              occ_d             = occ_q + 1'b1;
            end
          end
        end else if (hit) begin
          done          = 1'b1;
          resp_status_d = ST_OK;
          resp_sid_d    = sid_q[idx_q];
          resp_px_d     = px_q[idx_q];
          if (m_type_q == DEL_CODE || m_qty_q >= qty_q[idx_q]) begin
            valid_d[idx_q] = 1'b0;
            occ_d          = occ_q - 1'b1;
            resp_qty_d     = '0;
          end else begin
            qty_d[idx_q] = qty_q[idx_q] - m_qty_q;
            resp_qty_d   = qty_q[idx_q] - m_qty_q;
          end
        end else if (last) begin
          done          = 1'b1;
          resp_status_d = ST_NOT_FOUND;
          resp_sid_d    = '0;
          resp_px_d     = '0;
          resp_qty_d    = '0;
        end
        if (done) state_d = COMMIT;
        else      idx_d   = idx_q + 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef ORDER_TABLE_STATS_EN
  logic [15:0] add_cnt_q, add_cnt_d, del_cnt_q, del_cnt_d, exec_cnt_q, exec_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    add_cnt_d  = add_cnt_q;
    del_cnt_d  = del_cnt_q;
    exec_cnt_d = exec_cnt_q;
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (state_q == COMMIT) begin
      if (resp_status_q != ST_OK) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 1'b1;
      end else if (resp_type_q == ADD_CODE) begin
        if (add_cnt_q != 16'hFFFF) add_cnt_d = add_cnt_q + 1'b1;
      end else if (resp_type_q == DEL_CODE) begin
        if (del_cnt_q != 16'hFFFF) del_cnt_d = del_cnt_q + 1'b1;
      end else if (resp_type_q == EXEC_CODE) begin
        if (exec_cnt_q != 16'hFFFF) exec_cnt_d = exec_cnt_q + 1'b1;
      end
    end
    if (msg_drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_cnt_q  <= '0;
      del_cnt_q  <= '0;
      exec_cnt_q <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      add_cnt_q  <= add_cnt_d;
      del_cnt_q  <= del_cnt_d;
      exec_cnt_q <= exec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign add_cnt  = add_cnt_q;
  assign del_cnt  = del_cnt_q;
  assign exec_cnt = exec_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      occ_q         <= '0;
      m_type_q      <= '0;
      m_sid_q       <= '0;
      m_oid_q       <= '0;
      m_px_q        <= '0;
      m_qty_q       <= '0;
      resp_type_q   <= '0;
      resp_status_q <= '0;
      resp_oid_q    <= '0;
      resp_sid_q    <= '0;
      resp_px_q     <= '0;
      resp_qty_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        oid_q[i]   <= '0;
        sid_q[i]   <= '0;
        px_q[i]    <= '0;
        qty_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      occ_q         <= occ_d;
      m_type_q      <= m_type_d;
      m_sid_q       <= m_sid_d;
      m_oid_q       <= m_oid_d;
      m_px_q        <= m_px_d;
      m_qty_q       <= m_qty_d;
      resp_type_q   <= resp_type_d;
      resp_status_q <= resp_status_d;
      resp_oid_q    <= resp_oid_d;
      resp_sid_q    <= resp_sid_d;
      resp_px_q     <= resp_px_d;
      resp_qty_q    <= resp_qty_d;
      valid_q       <= valid_d;
      oid_q         <= oid_d;
      sid_q         <= sid_d;
      px_q          <= px_d;
      qty_q         <= qty_d;
    end
  end

  assign msg_ready     = (state_q == IDLE);
  assign msg_drop      = msg_valid && (state_q != IDLE);
  assign resp_valid    = (state_q == COMMIT);
  assign resp_type     = resp_type_q;
  assign resp_status   = resp_status_q;
  assign resp_order_id = resp_oid_q;
  assign resp_stock_id = resp_sid_q;
  assign resp_price    = resp_px_q;
  assign resp_qty_left = resp_qty_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_order_table.sv
// Scoreboard bench for order_table: directed messages push expected responses, a negedge monitor pops and compares.
module tb_order_table;

   localparam int DEPTH = 16;
   localparam logic [7:0] ADD  = 8'h41;
   localparam logic [7:0] DEL  = 8'h44;
   localparam logic [7:0] EXEC = 8'h45;
   localparam logic [2:0] OK = 3'd0, NF = 3'd1, FULL = 3'd2, DUP = 3'd3, BAD = 3'd4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        msg_valid = 1'b0;
   logic [7:0]  msg_type = '0;
   logic [7:0]  stock_id = '0;
   logic [31:0] order_id = '0;
   logic [31:0] price = '0;
   logic [31:0] quantity = '0;
   logic        msg_ready, msg_drop, resp_valid;
   logic [7:0]  resp_type, resp_stock_id;
   logic [2:0]  resp_status;
   logic [31:0] resp_order_id, resp_price, resp_qty_left;
   logic [$clog2(DEPTH+1)-1:0] occupancy;

   order_table #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_type(msg_type),
      .stock_id(stock_id), .order_id(order_id), .price(price), .quantity(quantity),
      .msg_ready(msg_ready), .msg_drop(msg_drop), .resp_valid(resp_valid),
      .resp_type(resp_type), .resp_status(resp_status), .resp_order_id(resp_order_id),
      .resp_stock_id(resp_stock_id), .resp_price(resp_price), .resp_qty_left(resp_qty_left),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  typ;
      logic [2:0]  st;
      logic [31:0] oid;
      logic [7:0]  sid;
      logic [31:0] px;
      logic [31:0] qty;
      int          occ;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int vectors = 0;
   int miscompares = 0;

   // Every comparison in the bench funnels through here so the summary counts stay honest.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] st, input logic [7:0] sid, input logic [31:0] px,
                               input logic [31:0] qty, input int occ, input int lat);
      exp_t e;
      e.typ = '0; e.oid = '0; e.acc = 0;
      e.st = st; e.sid = sid; e.px = px; e.qty = qty; e.occ = occ; e.lat = lat;
      return e;
   endfunction

   // Drives one message for a single cycle once the block is idle, optionally queuing its expected response.
   task automatic applyStimulus(input logic [7:0] t, input logic [7:0] s, input logic [31:0] o,
                                input logic [31:0] p, input logic [31:0] q, input bit push, input exp_t e);
      int n = 0;
      @(negedge clk);
      while (!msg_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!msg_ready) checkOutput("ready_timeout", {31'd0, msg_ready}, 32'd1);
      msg_type = t; stock_id = s; order_id = o; price = p; quantity = q;
      msg_valid = 1'b1;
      if (push) begin
         e.typ = t; e.oid = o; e.acc = cyc;
         sb.push_back(e);
      end
      @(negedge clk);
      msg_valid = 1'b0;
   endtask

   // Blocks until the monitor has consumed every queued expectation, with a bounded wait.
   task automatic waitResp();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checkOutput("resp_timeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   always @(negedge clk) begin
      if (!reset && resp_valid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_resp", {31'd0, resp_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("latency", cyc - e.acc, e.lat);
            checkOutput("resp_type", {24'd0, resp_type}, {24'd0, e.typ});
            checkOutput("resp_status", {29'd0, resp_status}, {29'd0, e.st});
            checkOutput("resp_order_id", resp_order_id, e.oid);
            checkOutput("resp_stock_id", {24'd0, resp_stock_id}, {24'd0, e.sid});
            checkOutput("resp_price", resp_price, e.px);
            checkOutput("resp_qty_left", resp_qty_left, e.qty);
            checkOutput("occupancy", {27'd0, occupancy}, e.occ);
         end
      end
   end

   exp_t none;

   initial begin
      none = mk(OK, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", {31'd0, msg_ready}, 32'd1);
      checkOutput("reset_occ", {27'd0, occupancy}, 32'd0);
      checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("reset_resp_status", {29'd0, resp_status}, 32'd0);
      reset = 1'b0;

      $display("[TB] add / duplicate / execute on a single order");
      applyStimulus(ADD, 8'd7, 32'h11, 32'd100, 32'd50, 1, mk(OK, 8'd7, 32'd100, 32'd50, 1, 17));
      waitResp();
      applyStimulus(ADD, 8'd8, 32'h11, 32'd5, 32'd3, 1, mk(DUP, 8'd8, 32'd5, 32'd0, 1, 2));
      waitResp();
      applyStimulus(EXEC, 8'd0, 32'h11, 32'd0, 32'd20, 1, mk(OK, 8'd7, 32'd100, 32'd30, 1, 2));
      waitResp();
      applyStimulus(EXEC, 8'd0, 32'h11, 32'd0, 32'd40, 1, mk(OK, 8'd7, 32'd100, 32'd0, 0, 2));
      waitResp();

      $display("[TB] fill table, overflow, delete at last slot");
      for (int i = 1; i <= DEPTH; i++) begin
         applyStimulus(ADD, 8'(i), 32'(i), 32'(1000 + i), 32'(i * 10), 1,
                       mk(OK, 8'(i), 32'(1000 + i), 32'(i * 10), i, 17));
         waitResp();
      end
      applyStimulus(ADD, 8'd9, 32'd99, 32'd5, 32'd5, 1, mk(FULL, 8'd9, 32'd5, 32'd0, 16, 17));
      waitResp();
      applyStimulus(DEL, 8'd0, 32'd16, 32'd0, 32'd0, 1, mk(OK, 8'd16, 32'd1016, 32'd0, 15, 17));
      waitResp();
      applyStimulus(DEL, 8'd0, 32'd16, 32'd0, 32'd0, 1, mk(NF, 8'd0, 32'd0, 32'd0, 15, 17));
      waitResp();
      applyStimulus(EXEC, 8'd0, 32'd5, 32'd0, 32'd0, 1, mk(OK, 8'd5, 32'd1005, 32'd50, 15, 6));
      waitResp();
      applyStimulus(EXEC, 8'd0, 32'd3, 32'd0, 32'd100, 1, mk(OK, 8'd3, 32'd1003, 32'd0, 14, 4));
      waitResp();

      $display("[TB] bad type");
      applyStimulus(8'h5A, 8'd1, 32'h77, 32'd1, 32'd1, 1, mk(BAD, 8'd0, 32'd0, 32'd0, 14, 1));
      waitResp();

      $display("[TB] message dropped during scan");
      applyStimulus(ADD, 8'd20, 32'd200, 32'd300, 32'd77, 1, mk(OK, 8'd20, 32'd300, 32'd77, 15, 17));
      repeat (2) @(negedge clk);
      msg_type = DEL; order_id = 32'd1; msg_valid = 1'b1;
      #2;
      checkOutput("msg_drop", {31'd0, msg_drop}, 32'd1);
      checkOutput("ready_in_scan", {31'd0, msg_ready}, 32'd0);
      @(negedge clk);
      msg_valid = 1'b0;
      #2;
      checkOutput("msg_drop_clear", {31'd0, msg_drop}, 32'd0);
      waitResp();
      applyStimulus(EXEC, 8'd0, 32'd1, 32'd0, 32'd0, 1, mk(OK, 8'd1, 32'd1001, 32'd10, 15, 2));
      waitResp();
      applyStimulus(EXEC, 8'd0, 32'd200, 32'd0, 32'd7, 1, mk(OK, 8'd20, 32'd300, 32'd70, 15, 4));
      waitResp();

      $display("[TB] reset during scan");
      applyStimulus(ADD, 8'd1, 32'd300, 32'd1, 32'd1, 0, none);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("post_reset_occ", {27'd0, occupancy}, 32'd0);
      checkOutput("post_reset_ready", {31'd0, msg_ready}, 32'd1);
      repeat (20) @(negedge clk);
      checkOutput("post_reset_idle_ready", {31'd0, msg_ready}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/order_table.md
Name: order_table

Overview:
- Downstream consumer of the byte-stream message parser.
- Takes one decoded message per `msg_valid` pulse (ADD, DELETE or EXECUTE) and keeps a table of live orders. The table holds at most DEPTH entries, each storing order_id, stock_id, price and quantity.
- Searches the table sequentially, one entry per cycle, then commits the update and emits a one-cycle response event for the book/analytics stages that follow.

Parameters:
- DEPTH, 16, number of order slots (2..64).
- ADD_CODE, 8'h41, msg_type value for an add-order message.
- DEL_CODE, 8'h44, msg_type value for a delete-order message.
- EXEC_CODE, 8'h45, msg_type value for an execute message (partial or full fill).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- msg_valid  in  1  message present this cycle (driven by parser done)
- msg_type  in  8  message type code
- stock_id  in  8  stock identifier
- order_id  in  32  order identifier
- price  in  32  price; used for ADD only
- quantity  in  32  ADD quantity, or EXEC fill quantity
- msg_ready  out  1  block is idle and can accept a message
- msg_drop  out  1  one-cycle pulse: msg_valid arrived while msg_ready=0; the message is discarded
- resp_valid  out  1  response event, one-cycle pulse
- resp_type  out  8  msg_type of the completed message
- resp_status  out  3  0 OK, 1 NOT_FOUND, 2 TABLE_FULL, 3 DUPLICATE, 4 BAD_TYPE
- resp_order_id  out  32  order_id of the completed message
- resp_stock_id  out  8  ADD: input stock_id; DEL/EXEC hit: stored stock_id; else 0
- resp_price  out  32  ADD: input price; DEL/EXEC hit: stored price; else 0
- resp_qty_left  out  32  quantity remaining in the table after commit; 0 if the entry was removed or on error
- occupancy  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset (asynchronous): all entry valid bits cleared; state IDLE; occupancy=0; msg_ready=1; msg_drop=0; resp_valid=0; all resp_* fields 0. A message in flight when reset asserts is lost with no response.
- States: IDLE, SCAN, COMMIT. msg_ready = (state==IDLE). resp_valid = (state==COMMIT). resp_* fields are registered and stable while resp_valid=1. There is no backpressure on the response.
- IDLE:
  - On msg_valid, latch all inputs.
  - Known type: go to SCAN with index 0.
  - Unknown type: go straight to COMMIT with status BAD_TYPE.
- SCAN: examine entry[idx] once per cycle.
  - ADD: track the lowest-index free slot. A valid entry with equal order_id sets the duplicate flag and ends the scan. Otherwise the scan always runs all DEPTH entries.
  - DEL/EXEC: a valid entry with equal order_id records the hit index and ends the scan at that index. Without a hit the scan ends after idx=DEPTH-1.
  - Next state after SCAN is always COMMIT.
- COMMIT (one cycle; table, occupancy and resp_* are written at the edge entering this state or during it, and are visible while resp_valid=1):
  - ADD, duplicate found: status DUPLICATE; table unchanged.
  - ADD, no free slot: status TABLE_FULL; table unchanged.
  - ADD, otherwise: write the lowest free slot; occupancy+1; resp_qty_left = quantity.
  - DEL, hit: clear the entry; occupancy−1; resp_qty_left=0.
  - DEL/EXEC, miss: status NOT_FOUND.
  - EXEC, hit with quantity >= stored qty: clear the entry; occupancy−1; resp_qty_left=0.
  - EXEC, hit with quantity < stored qty: stored qty −= quantity; resp_qty_left = new qty.
  - EXEC with quantity 0 is a legal hit: no change to the entry, status OK.
  - COMMIT always returns to IDLE.
- Latency from the accept cycle to resp_valid:
  - ADD: DEPTH+1 cycles; a duplicate at index k gives k+2.
  - DEL/EXEC: k+2 cycles for a hit at index k; DEPTH+1 cycles for a miss.
  - BAD_TYPE: 1 cycle.
- msg_valid during SCAN or COMMIT: msg_drop pulses in the same cycle (combinational); the message is not queued and table state is unaffected.
- occupancy never exceeds DEPTH and never underflows.
- Equal order_ids for different stock_ids count as the same order; order_id is globally unique.

Optional Feature:
- Macro: ORDER_TABLE_STATS_EN.
- Defined: adds outputs add_cnt, del_cnt, exec_cnt, err_cnt (16 bits each) and drop_cnt (16 bits).
  - add_cnt, del_cnt, exec_cnt count OK responses of each type.
  - err_cnt counts any non-OK response.
  - drop_cnt counts msg_drop pulses.
  - All counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- ADD id=0x11, px=100, qty=50 after reset -> resp_valid 17 cycles after accept; status OK; qty_left=50; occupancy=1.
- Same ADD id=0x11 again -> status DUPLICATE, resp_valid 2 cycles after accept (hit at index 0); occupancy stays 1.
- EXEC id=0x11 qty=20 -> OK, qty_left=30, resp_price=100. Then EXEC qty=40 -> OK, qty_left=0, occupancy=0.
- Fill all 16 slots with ids 1..16, then ADD id=99 -> TABLE_FULL; DEL id=16 -> OK at 17 cycles (hit index 15); DEL id=16 again -> NOT_FOUND.
- msg_type=8'h5A -> BAD_TYPE, resp_valid 1 cycle after accept. A msg_valid during any SCAN -> msg_drop=1 that cycle; table unchanged.
- Assert reset mid-SCAN of an ADD -> no resp_valid, occupancy=0, msg_ready=1 on the first cycle after reset deasserts.
